mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/mem_sequencer_pkg.sv | 23 ++
 rtl/mem_sequencer_tristate.sv | 14 +
 rtl/mem_sequencer.sv | 115 +++++++++++
 tb/tb_mem_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_sequencer_pkg.sv
// Shared definitions for the SRAM access sequencer: the state encoding,
// default widths and the I/O-mapped address.
package mem_sequencer_pkg;

    localparam int              MAR_W       = 16;
    localparam int              DATA_W_DEF  = 16;
    localparam int              ADDR_W_DEF  = 20;
    localparam logic [15:0]     IO_ADDR_DEF = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        WR_SETUP = 3'd2,
        WR_PULSE = 3'd3,
        WR_DONE  = 3'd4
    } seq_state_t;

    // True for every state in which the write data belongs on the bus.
    function automatic logic is_write_state(input seq_state_t s);
        return (s == WR_SETUP) || (s == WR_PULSE) || (s == WR_DONE);
    endfunction

endpackage

// File: rtl/mem_sequencer_tristate.sv
// Bidirectional pad driver for the SRAM data bus.
module sram_tristate #(
    parameter int DATA_W = 16
) (
    input  logic              oe,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    inout  wire  [DATA_W-1:0] pad
);

    assign pad   = oe ? wdata : {DATA_W{1'bz}};
    assign rdata = pad;

endmodule

// File: rtl/mem_sequencer.sv
// SRAM access sequencer: turns the CPU's active-low memory requests into
// SRAM strobes, with a fixed setup/pulse/hold write and an I/O-mapped word
// (switches on read, hex register on write).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no access; waits for a read or write request
// RD       | SRAM output enabled, read data captured every cycle
// WR_SETUP | data on the bus, WE_N still high (address/data setup)
// WR_PULSE | single WE_N-low cycle (or hex register load for IO_ADDR)
// WR_DONE  | data held, waits for Mem_WE release so one request = one write
module mem_sequencer
    import mem_sequencer_pkg::*;
#(
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter int                DATA_W  = DATA_W_DEF,
    parameter logic [MAR_W-1:0]  IO_ADDR = IO_ADDR_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_CE,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic [MAR_W-1:0]  MAR,
    input  logic [DATA_W-1:0] MDR,
    input  logic [DATA_W-1:0] Switches,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic [DATA_W-1:0] Hex_reg,
    output logic              Mem_busy,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [DATA_W-1:0] SRAM_DQ,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N
);

    seq_state_t        state;
    seq_state_t        state_next;
    logic              is_io;
    logic              dq_drive;
    logic [DATA_W-1:0] dq_in;

    assign is_io     = (MAR == IO_ADDR);
    assign SRAM_ADDR = ADDR_W'(MAR);
    assign SRAM_CE_N = Mem_CE;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

    // State register; reset wins over any pending request.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode; a deselected chip always returns to IDLE.
    always_comb begin
        state_next = state;
        if (Mem_CE) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (!Mem_WE)      state_next = WR_SETUP;
                    else if (!Mem_OE) state_next = RD;
                end
                RD:       if (Mem_OE) state_next = IDLE;
                WR_SETUP: state_next = WR_PULSE;
                WR_PULSE: state_next = WR_DONE;
                WR_DONE:  if (Mem_WE) state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Strobe and bus-enable decode from the current state.
    always_comb begin
        Mem_busy  = 1'b0;
        SRAM_OE_N = 1'b1;
        SRAM_WE_N = 1'b1;
        dq_drive  = is_write_state(state) && !is_io;
        case (state)
            RD:       SRAM_OE_N = 1'b0;
            WR_SETUP: Mem_busy  = 1'b1;
            WR_PULSE: begin
                Mem_busy  = 1'b1;
                SRAM_WE_N = is_io || Mem_CE;
            end
            default: ;
        endcase
    end

    // Read capture and hex register load. Capture is skipped once Mem_CE
    // rises, because the SRAM has already released the bus by then.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Data_to_CPU <= '0;
            Hex_reg     <= '0;
        end else begin
            if (state == RD && !Mem_CE)
                Data_to_CPU <= is_io ? Switches : dq_in;
            if (state == WR_PULSE && is_io && !Mem_CE)
                Hex_reg <= MDR;
        end
    end

    sram_tristate #(.DATA_W(DATA_W)) u_tri (
        .oe    (dq_drive),
        .wdata (MDR),
        .rdata (dq_in),
        .pad   (SRAM_DQ)
    );

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a small behavioural SRAM on the bus.
module tb_mem_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Mem_CE, Mem_OE, Mem_WE;
    logic [15:0] MAR, MDR, Switches;
    logic [15:0] Data_to_CPU, Hex_reg;
    logic        Mem_busy;
    logic [19:0] SRAM_ADDR;
    wire  [15:0] SRAM_DQ;
    logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;

    mem_sequencer dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Mem_CE      (Mem_CE),
        .Mem_OE      (Mem_OE),
        .Mem_WE      (Mem_WE),
        .MAR         (MAR),
        .MDR         (MDR),
        .Switches    (Switches),
        .Data_to_CPU (Data_to_CPU),
        .Hex_reg     (Hex_reg),
        .Mem_busy    (Mem_busy),
        .SRAM_ADDR   (SRAM_ADDR),
        .SRAM_DQ     (SRAM_DQ),
        .SRAM_CE_N   (SRAM_CE_N),
        .SRAM_OE_N   (SRAM_OE_N),
        .SRAM_WE_N   (SRAM_WE_N),
        .SRAM_UB_N   (SRAM_UB_N),
        .SRAM_LB_N   (SRAM_LB_N)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // SRAM model: 256 words, low address byte only, plus a preload port.
    logic [15:0] mem [0:255];
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [15:0] ld_data;
    int          wr_count;

    assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[7:0]] : 16'bz;

    always @(posedge Clk) begin
        if (ld_en)
            mem[ld_addr] <= ld_data;
        else if (!SRAM_CE_N && !SRAM_WE_N) begin
            mem[SRAM_ADDR[7:0]] <= SRAM_DQ;
            wr_count <= wr_count + 1;
        end
    end

    int n_err;
    int n_checks;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] a, input logic [15:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge Clk); #1;
        ld_en   = 1'b0;
    endtask

    // Per-cycle observation masks, bit c = cycle c of the last sequence.
    logic [7:0]  oe_m, we_m, busy_m, drv_m, cen_m, ublb_m;
    logic [15:0] data_log [0:7];
    logic [19:0] addr_log [0:7];

    // Inputs for cycle c come from bit c of each vector (bit 0 unused);
    // observations are taken at the falling edge of that cycle.
    task automatic run_seq(input int n, input logic [7:0] ce_v, input logic [7:0] oe_v,
                           input logic [7:0] we_v, input logic [7:0] rst_v);
        oe_m = '0; we_m = '0; busy_m = '0; drv_m = '0; cen_m = '0; ublb_m = '0;
        for (int c = 1; c <= n; c++) begin
            Mem_CE = ce_v[c];
            Mem_OE = oe_v[c];
            Mem_WE = we_v[c];
            Reset  = rst_v[c];
            @(negedge Clk);
            oe_m[c]     = !SRAM_OE_N;
            we_m[c]     = !SRAM_WE_N;
            busy_m[c]   = Mem_busy;
            drv_m[c]    = dut.dq_drive;
            cen_m[c]    = !SRAM_CE_N;
            ublb_m[c]   = SRAM_UB_N | SRAM_LB_N;
            data_log[c] = Data_to_CPU;
            addr_log[c] = SRAM_ADDR;
            @(posedge Clk); #1;
        end
        Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1; Reset = 1'b0;
    endtask

    initial begin
        n_err = 0; n_checks = 0; wr_count = 0;
        Reset = 1'b1; Mem_CE = 1'b1; Mem_OE = 1'b1; Mem_WE = 1'b1;
        MAR = '0; MDR = '0; Switches = '0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        @(posedge Clk); #1;
        load(8'h10, 16'hBEEF);
        load(8'h20, 16'h0000);
        load(8'h30, 16'h0000);
        load(8'h40, 16'h1111);
        load(8'h50, 16'hCAFE);
        load(8'hFF, 16'h7777);

        // Reset holds everything quiet even with a write request pending.
        Mem_CE = 1'b0; Mem_WE = 1'b0;
        @(posedge Clk); #1;
        @(negedge Clk);
        check("rst_data",  32'(Data_to_CPU), 32'h0);
        check("rst_hex",   32'(Hex_reg),     32'h0);
        check("rst_busy",  32'(Mem_busy),    32'h0);
        check("rst_oe_n",  32'(SRAM_OE_N),   32'h1);
        check("rst_we_n",  32'(SRAM_WE_N),   32'h1);
        check("rst_drv",   32'(dut.dq_drive), 32'h0);
        @(posedge Clk); #1;
        Mem_CE = 1'b1; Mem_WE = 1'b1; Reset = 1'b0;
        @(posedge Clk); #1;

        // Plain read of 0x0010: OE low cycles 1-2, SRAM_OE_N low cycles 2-3.
        MAR = 16'h0010;
        run_seq(5, 8'h00, 8'hF9, 8'hFF, 8'h00);
        check("rd_oe_cycles", 32'(oe_m),  32'h0C);
        check("rd_we_cycles", 32'(we_m),  32'h00);
        check("rd_data_c2",   32'(data_log[2]), 32'h0);
        check("rd_data_c3",   32'(data_log[3]), 32'hBEEF);
        check("rd_data_hold", 32'(data_log[5]), 32'hBEEF);
        check("rd_addr",      32'(addr_log[2]), 32'h00010);
        check("rd_ce_n",      32'(cen_m),  32'h3E);
        check("rd_ub_lb",     32'(ublb_m), 32'h00);
        check("rd_no_drive",  32'(drv_m),  32'h00);

        // Write 0x1234 to 0x0020 with Mem_WE low for five cycles.
        MAR = 16'h0020; MDR = 16'h1234;
        run_seq(7, 8'hC1, 8'hFF, 8'hC1, 8'h00);
        check("wr_we_cycles",   32'(we_m),   32'h08);
        check("wr_busy_cycles", 32'(busy_m), 32'h0C);
        check("wr_drive",       32'(drv_m),  32'h7C);
        check("wr_oe_cycles",   32'(oe_m),   32'h00);
        check("wr_mem",         32'(mem[8'h20]), 32'h1234);
        check("wr_count",       32'(wr_count), 32'd1);

        // IO read returns the switches, not SRAM contents.
        MAR = 16'hFFFF; Switches = 16'h00A5;
        run_seq(5, 8'h00, 8'hF9, 8'hFF, 8'h00);
        check("io_rd_data", 32'(data_log[3]), 32'h00A5);
        check("io_rd_oe",   32'(oe_m), 32'h0C);

        // IO write loads the hex register and leaves the SRAM alone.
        MDR = 16'h0042;
        run_seq(6, 8'hF1, 8'hFF, 8'hF1, 8'h00);
        check("io_wr_we",    32'(we_m),   32'h00);
        check("io_wr_drive", 32'(drv_m),  32'h00);
        check("io_wr_busy",  32'(busy_m), 32'h0C);
        check("io_wr_hex",   32'(Hex_reg), 32'h0042);
        check("io_wr_count", 32'(wr_count), 32'd1);

        // OE and WE low together: the write wins and OE_N never drops.
        MAR = 16'h0030; MDR = 16'h5A5A;
        run_seq(6, 8'hF1, 8'hF1, 8'hF1, 8'h00);
        check("both_oe",  32'(oe_m), 32'h00);
        check("both_we",  32'(we_m), 32'h08);
        check("both_mem", 32'(mem[8'h30]), 32'h5A5A);
        check("both_cnt", 32'(wr_count), 32'd2);

        // Reset during WR_SETUP abandons the write.
        MAR = 16'h0040; MDR = 16'hDEAD;
        run_seq(6, 8'hF9, 8'hFF, 8'hF9, 8'h04);
        check("rstw_we",   32'(we_m),   32'h00);
        check("rstw_busy", 32'(busy_m), 32'h04);
        check("rstw_mem",  32'(mem[8'h40]), 32'h1111);
        check("rstw_hex",  32'(Hex_reg), 32'h0);
        check("rstw_cnt",  32'(wr_count), 32'd2);

        // Mem_CE rises during RD: back to IDLE, data keeps the last capture.
        MAR = 16'h0050; Switches = 16'h00A5;
        run_seq(2, 8'h00, 8'h00, 8'hFF, 8'h00);
        MAR = 16'hFFFF; Mem_CE = 1'b1; Mem_OE = 1'b0;
        @(negedge Clk);
        check("ce_rd_oe_c3",  32'(SRAM_OE_N), 32'h0);
        check("ce_rd_data_c3", 32'(Data_to_CPU), 32'hCAFE);
        @(posedge Clk); #1;
        Mem_OE = 1'b1;
        @(negedge Clk);
        check("ce_rd_oe_c4",   32'(SRAM_OE_N), 32'h1);
        check("ce_rd_data_c4", 32'(Data_to_CPU), 32'hCAFE);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("ce_rd_data_c5", 32'(Data_to_CPU), 32'hCAFE);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
